mc_ctrl: RTL

//  Multicycle control FSM for the MIPS-lite core. Sequences the PC register, IR, register file,
//  ALU and data memory, one instruction at a time, with ready handshakes to instruction and data memory.

---
 rtl/mc_ctrl_pkg.sv | 78 +++++++
 rtl/mc_ctrl_instr_dec.sv | 32 +++
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared codes for the multicycle MIPS-lite control path and its datapath muxes.
// Holds state encodings, opcode/funct constants, select codes and the class bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MADDR  = 4'd4,
        S_MREAD  = 4'd5,
        S_MWB    = 4'd6,
        S_MWRITE = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_SLT    = 6'h2a;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BEQ  = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
    } cls_t;

    function automatic logic [2:0] alu_of(input logic       ori,
                                          input logic       lui,
                                          input logic [5:0] funct);
        if (ori)                 return ALU_OR;
        else if (lui)            return ALU_LUI;
        else if (funct == F_SUBU) return ALU_SUBU;
        else if (funct == F_SLT)  return ALU_SLT;
        else                     return ALU_ADDU;
    endfunction

endpackage

// File: rtl/mc_ctrl_instr_dec.sv
// Instruction class decoder for mc_ctrl: op/funct to a one-hot class.
// Purely combinational; anything unsupported lands in the illegal class.
module instr_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU, F_SUBU, F_SLT: cls.rtype_alu = 1'b1;
                    F_JR:                  cls.jr        = 1'b1;
                    default:               cls.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-lite core: state register, next state, output decode.
// Optional perf counters cycle_cnt/retire_cnt are built when CTRL_PERF_EN is defined.
module mc_ctrl
    import mc_ctrl_pkg::*;
`ifdef CTRL_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       im_ready,
    input  logic       dm_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] NPCOp,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       BSel,
    output logic [1:0] EXTOp,
    output logic       illegal
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    state_e     state_q, state_d;
    cls_t       cls;
    logic [2:0] aluop_q;
    logic       r_q, lw_q, jal_q, jr_q;

    instr_dec u_dec (
        .op   (op),
        .funct(funct),
        .cls  (cls)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (im_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    cls.rtype_alu, cls.ori, cls.lui: state_d = S_EXEC;
                    cls.lw, cls.sw:                  state_d = S_MADDR;
                    cls.beq:                         state_d = S_BRANCH;
                    cls.j, cls.jal, cls.jr:          state_d = S_JUMP;
                    cls.illegal:                     state_d = S_FETCH;
                    default:                         state_d = S_FETCH;
                endcase
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_MADDR:  state_d = lw_q ? S_MREAD : S_MWRITE;
            S_MREAD:  if (dm_ready) state_d = S_MWB;
            S_MWB:    state_d = S_FETCH;
            S_MWRITE: if (dm_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Class bits are captured in DECODE so later states do not depend on IR timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            aluop_q <= ALU_ADDU;
            r_q     <= 1'b0;
            lw_q    <= 1'b0;
            jal_q   <= 1'b0;
            jr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                aluop_q <= alu_of(cls.ori, cls.lui, funct);
                r_q     <= cls.rtype_alu;
                lw_q    <= cls.lw;
                jal_q   <= cls.jal;
                jr_q    <= cls.jr;
            end
        end
    end

    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        NPCOp   = NPC_PC4;
        ALUOp   = ALU_ADDU;
        RegDst  = RD_RT;
        WDSel   = WD_ALU;
        BSel    = 1'b0;
        EXTOp   = EXT_ZERO;
        illegal = 1'b0;
        if (rst) begin
            unique case (state_q)
                S_FETCH: begin
                    IRWr = 1'b1;
                    PCWr = im_ready;
                end
                S_DECODE: illegal = cls.illegal;
                S_EXEC, S_ALUWB: begin
                    ALUOp = aluop_q;
                    BSel  = ~r_q;
                    EXTOp = (aluop_q == ALU_LUI) ? EXT_LUI : EXT_ZERO;
                    if (state_q == S_ALUWB) begin
                        RFWr   = 1'b1;
                        WDSel  = WD_ALU;
                        RegDst = r_q ? RD_RD : RD_RT;
                    end
                end
                S_MADDR: begin
                    ALUOp = ALU_ADDU;
                    BSel  = 1'b1;
                    EXTOp = EXT_SIGN;
                end
                S_MWB: begin
                    RFWr   = 1'b1;
                    WDSel  = WD_DM;
                    RegDst = RD_RT;
                end
                S_MWRITE: DMWr = 1'b1;
                S_BRANCH: begin
                    ALUOp = ALU_SUBU;
                    NPCOp = NPC_BEQ;
                    PCWr  = zero;
                end
                S_JUMP: begin
                    PCWr  = 1'b1;
                    NPCOp = jr_q ? NPC_JR : NPC_JMP;
                    if (jal_q) begin
                        RFWr   = 1'b1;
                        RegDst = RD_RA;
                        WDSel  = WD_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic             retire;

    // DECODE only returns to FETCH on an illegal op, which does not retire.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                    (state_q != S_DECODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt  = cyc_q;
    assign retire_cnt = ret_q;
`endif

endmodule
